// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access-size selects, FSM states, lane-mask width.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    localparam int LANE_MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction/extension and store byte-mask plus data replication.
// Defining DMEM_MISALIGN_CHECK_EN flags unaligned half/word accesses instead of aligning them down.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]             addr_lo,
    input  logic                   we,
    input  logic [2:0]             load_sel,
    input  logic [1:0]             store_sel,
    input  logic [31:0]            wdata,
    input  logic [31:0]            rword,
    output logic [31:0]            rdata,
    output logic [LANE_MASK_W-1:0] wmask,
    output logic [31:0]            wdata_rep,
    output logic                   sel_err,
    output logic                   misalign_err
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        load_bad;
    logic        store_bad;

    always_comb begin
        rbyte     = 8'h00;
        rdata     = 32'h0;
        load_bad  = 1'b0;
        wmask     = '0;
        wdata_rep = 32'h0;
        store_bad = 1'b0;

        case (addr_lo)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        // Half lane comes from addr[1] only, so addr[0] is ignored unless the check is enabled.
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (load_sel)
            LD_LB:   rdata = {{24{rbyte[7]}}, rbyte};
            LD_LH:   rdata = {{16{rhalf[15]}}, rhalf};
            LD_LW:   rdata = rword;
            LD_LBU:  rdata = {24'h0, rbyte};
            LD_LHU:  rdata = {16'h0, rhalf};
            default: load_bad = 1'b1;
        endcase

        case (store_sel)
            ST_SB: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            ST_SH: begin
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            ST_SW: begin
                wmask     = 4'b1111;
                wdata_rep = wdata;
            end
            default: store_bad = 1'b1;
        endcase

        sel_err = we ? store_bad : load_bad;

`ifdef DMEM_MISALIGN_CHECK_EN
        if (we)
            misalign_err = ((store_sel == ST_SH) && addr_lo[0]) ||
                           ((store_sel == ST_SW) && (addr_lo != 2'd0));
        else
            misalign_err = (((load_sel == LD_LH) || (load_sel == LD_LHU)) && addr_lo[0]) ||
                           ((load_sel == LD_LW) && (addr_lo != 2'd0));
`else
        misalign_err = 1'b0;
`endif
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable wait states and RISC-V load/store lane rules.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned half/word accesses report an error).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load_sel,
    input  logic [1:0]  req_store_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    logic [31:0] mem [DEPTH_WORDS];

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [29:0]            word_off;
    logic                   in_range;
    logic [IDX_W-1:0]       mem_idx;
    logic [31:0]            rword;
    logic [31:0]            align_rdata;
    logic [LANE_MASK_W-1:0] wmask;
    logic [31:0]            wdata_rep;
    logic                   sel_err;
    logic                   misalign_err;
    logic                   acc_err;
    logic [31:0]            acc_rdata;
    logic                   accept;
    logic                   wr_en;

    // Both bounds are checked on the full word offset so addresses below BASE_ADDR cannot wrap into range.
    always_comb begin
        word_off  = req_addr[31:2] - BASE_W;
        in_range  = (req_addr[31:2] >= BASE_W) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
        mem_idx   = word_off[IDX_W-1:0];
        rword     = mem[mem_idx];
        acc_err   = !in_range || sel_err || misalign_err;
        acc_rdata = (req_we || acc_err) ? 32'h0 : align_rdata;
        accept    = req_valid && req_ready;
        wr_en     = accept && req_we && !acc_err;
    end

    dmem_lane_align u_lane_align (
        .addr_lo      (req_addr[1:0]),
        .we           (req_we),
        .load_sel     (req_load_sel),
        .store_sel    (req_store_sel),
        .wdata        (req_wdata),
        .rword        (rword),
        .rdata        (align_rdata),
        .wmask        (wmask),
        .wdata_rep    (wdata_rep),
        .sel_err      (sel_err),
        .misalign_err (misalign_err)
    );

    // Stores commit at the accept edge and the array has no reset, so a later reset cannot undo them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANE_MASK_W; i++) begin
            if (wr_en && wmask[i])
                mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rdata <= acc_rdata;
                        rsp_err   <= acc_err;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=1 instance (dut_a) and a WAIT_CYCLES=0 instance (dut_b).
// Expected values follow DMEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic        MIS_ERR   = 1'b1;
    localparam logic [31:0] AFTER_MIS = 32'h8001BEEF;
    localparam logic        LH13_ERR  = 1'b1;
    localparam logic [31:0] LH13_DATA = 32'h0000_0000;
`else
    localparam logic        MIS_ERR   = 1'b0;
    localparam logic [31:0] AFTER_MIS = 32'hCAFEF00D;
    localparam logic        LH13_ERR  = 1'b0;
    localparam logic [31:0] LH13_DATA = 32'hFFFFCAFE;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_load_sel;
    logic [1:0]  req_store_sel;

    logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    typedef struct {
        bit          dut;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  lsel;
        logic [1:0]  ssel;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    function automatic vec_t ld(bit d, logic [31:0] a, logic [2:0] ls, logic [31:0] er, logic ee);
        vec_t v;
        v.dut = d; v.we = 1'b0; v.addr = a; v.wdata = 32'h0; v.lsel = ls; v.ssel = ST_SB;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic vec_t st(bit d, logic [31:0] a, logic [31:0] wd, logic [1:0] ss, logic ee);
        vec_t v;
        v.dut = d; v.we = 1'b1; v.addr = a; v.wdata = wd; v.lsel = LD_LW; v.ssel = ss;
        v.exp_rdata = 32'h0; v.exp_err = ee;
        return v;
    endfunction

    task automatic checkOutput(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s #%0d: got %h, expected %h", what, idx, act, exp);
        end
    endtask

    // One full transaction; lat counts clock edges after the accept edge until rsp_valid is seen.
    task automatic applyStimulus(input vec_t v, output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_we        = v.we;
        req_addr      = v.addr;
        req_wdata     = v.wdata;
        req_load_sel  = v.lsel;
        req_store_sel = v.ssel;
        if (v.dut) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = 0;
        while (!(v.dut ? rsp_valid_b : rsp_valid_a) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = v.dut ? rsp_rdata_b : rsp_rdata_a;
        err   = v.dut ? rsp_err_b : rsp_err_a;
        if (v.dut) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_load_sel = LD_LW; req_store_sel = ST_SW;

        vecs.push_back(st(0, 32'h10, 32'hDEADBEEF, ST_SW, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LW,  32'hDEADBEEF, 1'b0));
        vecs.push_back(st(0, 32'h13, 32'h00000080, ST_SB, 1'b0));
        vecs.push_back(ld(0, 32'h13, LD_LB,  32'hFFFFFF80, 1'b0));
        vecs.push_back(ld(0, 32'h13, LD_LBU, 32'h00000080, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LW,  32'h80ADBEEF, 1'b0));
        vecs.push_back(st(0, 32'h12, 32'h00008001, ST_SH, 1'b0));
        vecs.push_back(ld(0, 32'h12, LD_LH,  32'hFFFF8001, 1'b0));
        vecs.push_back(ld(0, 32'h12, LD_LHU, 32'h00008001, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LW,  32'h8001BEEF, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LB,  32'hFFFFFFEF, 1'b0));
        vecs.push_back(ld(0, 32'h11, LD_LBU, 32'h000000BE, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LH,  32'hFFFFBEEF, 1'b0));
        vecs.push_back(ld(0, 32'h10, LD_LHU, 32'h0000BEEF, 1'b0));
        vecs.push_back(ld(0, 32'h1000, LD_LW, 32'h0, 1'b1));
        vecs.push_back(st(0, 32'h1000, 32'h55555555, ST_SW, 1'b1));
        vecs.push_back(ld(0, 32'h10, 3'b011, 32'h0, 1'b1));
        vecs.push_back(st(0, 32'h10, 32'h12345678, 2'b11, 1'b1));
        vecs.push_back(ld(0, 32'h10, LD_LW,  32'h8001BEEF, 1'b0));
        vecs.push_back(st(0, 32'h11, 32'hCAFEF00D, ST_SW, MIS_ERR));
        vecs.push_back(ld(0, 32'h10, LD_LW,  AFTER_MIS, 1'b0));
        vecs.push_back(ld(0, 32'h13, LD_LH,  LH13_DATA, LH13_ERR));
        vecs.push_back(st(1, 32'h40, 32'h12345678, ST_SW, 1'b0));
        vecs.push_back(ld(1, 32'h40, LD_LW,  32'h12345678, 1'b0));
        vecs.push_back(ld(1, 32'h41, LD_LBU, 32'h00000056, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 0, {31'b0, rsp_valid_a}, 32'd0);
        checkOutput("reset_rsp_rdata", 0, rsp_rdata_a, 32'd0);
        checkOutput("reset_rsp_err",   0, {31'b0, rsp_err_a}, 32'd0);
        checkOutput("reset_req_ready", 0, {31'b0, req_ready_a}, 32'd1);
        checkOutput("reset_req_ready", 1, {31'b0, req_ready_b}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], got_rdata, got_err, got_lat);
            checkOutput("rdata",   i, got_rdata, vecs[i].exp_rdata);
            checkOutput("err",     i, {31'b0, got_err}, {31'b0, vecs[i].exp_err});
            checkOutput("latency", i, 32'(got_lat), vecs[i].dut ? 32'd0 : 32'd1);
        end

        // Back-pressure: response held for 5 cycles while a store is offered and must be ignored.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_load_sel = LD_LW; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_store_sel = ST_SW; req_wdata = 32'h11111111; req_valid_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_rsp_valid", k, {31'b0, rsp_valid_a}, 32'd1);
            checkOutput("bp_rsp_rdata", k, rsp_rdata_a, AFTER_MIS);
            checkOutput("bp_req_ready", k, {31'b0, req_ready_a}, 32'd0);
        end
        @(negedge clk);
        req_valid_a = 1'b0;
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;
        checkOutput("bp_release_valid", 0, {31'b0, rsp_valid_a}, 32'd0);
        checkOutput("bp_release_ready", 0, {31'b0, req_ready_a}, 32'd1);
        applyStimulus(ld(0, 32'h10, LD_LW, AFTER_MIS, 1'b0), got_rdata, got_err, got_lat);
        checkOutput("bp_store_ignored", 0, got_rdata, AFTER_MIS);

        // Reset during WAIT: pending response dropped, committed store kept.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_store_sel = ST_SW; req_wdata = 32'h0BADCAFE; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        checkOutput("wait_req_ready", 0, {31'b0, req_ready_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_rsp_valid", 0, {31'b0, rsp_valid_a}, 32'd0);
        checkOutput("midrst_req_ready", 0, {31'b0, req_ready_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postrst_rsp_valid", 0, {31'b0, rsp_valid_a}, 32'd0);
        applyStimulus(ld(0, 32'h20, LD_LW, 32'h0BADCAFE, 1'b0), got_rdata, got_err, got_lat);
        checkOutput("committed_store", 0, got_rdata, 32'h0BADCAFE);
        checkOutput("committed_err",   0, {31'b0, got_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
